// File: rtl/stage_two_cordic_pkg.sv
// Shared definitions for the stage-two CORDIC engine: widths, FSM state
// encodings, the CORDIC gain seed and the atan(2^-i) table in Q1.20.
package stage_two_cordic_pkg;

    localparam int CRD_DATA_WIDTH = 22;
    localparam int FLT_DATA_WIDTH = 32;
    localparam int ITER_WIDTH     = 5;
    localparam int ITERATIONS_DEF = 16;

    localparam logic signed [CRD_DATA_WIDTH-1:0] ONE_Q20  = 22'sd1048576;
    localparam logic signed [CRD_DATA_WIDTH-1:0] K_INIT_DEF = 22'sd636751;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_FINISH = 2'd2
    } cordic_state_e;

    // atan(2^-i) * 2^20, rounded; entries beyond the legal iteration range read 0
    function automatic logic signed [CRD_DATA_WIDTH-1:0] atan_of(input logic [ITER_WIDTH-1:0] idx);
        logic signed [CRD_DATA_WIDTH-1:0] val;
        case (idx)
            5'd0:    val = 22'sd823550;
            5'd1:    val = 22'sd486170;
            5'd2:    val = 22'sd256879;
            5'd3:    val = 22'sd130396;
            5'd4:    val = 22'sd65451;
            5'd5:    val = 22'sd32757;
            5'd6:    val = 22'sd16383;
            5'd7:    val = 22'sd8192;
            5'd8:    val = 22'sd4096;
            5'd9:    val = 22'sd2048;
            5'd10:   val = 22'sd1024;
            5'd11:   val = 22'sd512;
            5'd12:   val = 22'sd256;
            5'd13:   val = 22'sd128;
            5'd14:   val = 22'sd64;
            5'd15:   val = 22'sd32;
            5'd16:   val = 22'sd16;
            5'd17:   val = 22'sd8;
            5'd18:   val = 22'sd4;
            5'd19:   val = 22'sd2;
            5'd20:   val = 22'sd1;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/stage_two_cordic_if.sv
// Request/result bundle between stage one, the CORDIC engine and the final
// combine stage. sin_out exists only when CORDIC_SIN_OUT_EN is defined.
interface stage_two_cordic_if;
    import stage_two_cordic_pkg::*;

    logic                             start;
    logic signed [CRD_DATA_WIDTH-1:0] theta;
    logic [FLT_DATA_WIDTH-1:0]        half_in;
    logic [FLT_DATA_WIDTH-1:0]        square_in;
    logic signed [CRD_DATA_WIDTH-1:0] cos_out;
`ifdef CORDIC_SIN_OUT_EN
    logic signed [CRD_DATA_WIDTH-1:0] sin_out;
`endif
    logic [FLT_DATA_WIDTH-1:0]        half_out;
    logic [FLT_DATA_WIDTH-1:0]        square_out;
    logic                             busy;
    logic                             done;

    modport master (
`ifdef CORDIC_SIN_OUT_EN
        input  sin_out,
`endif
        output start, theta, half_in, square_in,
        input  cos_out, half_out, square_out, busy, done
    );

    modport slave (
`ifdef CORDIC_SIN_OUT_EN
        output sin_out,
`endif
        input  start, theta, half_in, square_in,
        output cos_out, half_out, square_out, busy, done
    );

endinterface

// File: rtl/stage_two_cordic_atan_rom.sv
// Combinational atan(2^-i) lookup feeding the z-path of the CORDIC engine.
module cordic_atan_rom
    import stage_two_cordic_pkg::*;
(
    input  logic [ITER_WIDTH-1:0]            idx,
    output logic signed [CRD_DATA_WIDTH-1:0] atan_val
);

    // table lookup, pure combinational
    always_comb begin
        atan_val = atan_of(idx);
    end

endmodule

// File: rtl/stage_two_cordic.sv
// Iterative rotation-mode CORDIC: theta (Q1.20 rad) in, cos(theta) out,
// with stage one's half/square floats carried alongside the operation.
// Optional feature macro: CORDIC_SIN_OUT_EN adds sin_out (driven from y).
//
// state     | meaning
// ST_IDLE   | waiting for start; done pulse clears on the next enabled cycle
// ST_ROTATE | one micro-rotation per enabled cycle, iter 0..ITERATIONS-1
// ST_FINISH | publish result, pulse done, drop busy
module stage_two_cordic
    import stage_two_cordic_pkg::*;
#(
    parameter int                               ITERATIONS = ITERATIONS_DEF,  // legal 1..20
    parameter logic signed [CRD_DATA_WIDTH-1:0] K_INIT     = K_INIT_DEF
) (
    input  logic               clk,
    input  logic               rst,      // asynchronous, active-low
    input  logic               clk_en,
    stage_two_cordic_if.slave  bus
);

    localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(ITERATIONS - 1);

    cordic_state_e state_q, state_d;

    logic signed [CRD_DATA_WIDTH-1:0] x_q, x_d;
    logic signed [CRD_DATA_WIDTH-1:0] y_q, y_d;
    logic signed [CRD_DATA_WIDTH-1:0] z_q, z_d;
    logic signed [CRD_DATA_WIDTH-1:0] cos_q, cos_d;
`ifdef CORDIC_SIN_OUT_EN
    logic signed [CRD_DATA_WIDTH-1:0] sin_q, sin_d;
`endif
    logic [ITER_WIDTH-1:0]            iter_q, iter_d;
    logic [FLT_DATA_WIDTH-1:0]        half_q, half_d;
    logic [FLT_DATA_WIDTH-1:0]        square_q, square_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic signed [CRD_DATA_WIDTH-1:0] atan_val;
    logic signed [CRD_DATA_WIDTH-1:0] x_shift;
    logic signed [CRD_DATA_WIDTH-1:0] y_shift;
    logic                             dir_pos;

    cordic_atan_rom u_atan_rom (
        .idx      (iter_q),
        .atan_val (atan_val)
    );

    // arithmetic shifts and rotation direction for the current micro-rotation
    always_comb begin
        x_shift = x_q >>> iter_q;
        y_shift = y_q >>> iter_q;
        dir_pos = ~z_q[CRD_DATA_WIDTH-1];
    end

    // next-state and datapath; with clk_en low every register holds, including done
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        cos_d    = cos_q;
`ifdef CORDIC_SIN_OUT_EN
        sin_d    = sin_q;
`endif
        iter_d   = iter_q;
        half_d   = half_q;
        square_d = square_q;
        busy_d   = busy_q;
        done_d   = done_q;

        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    done_d = 1'b0;
                    if (bus.start) begin
                        x_d      = K_INIT;
                        y_d      = '0;
                        z_d      = bus.theta;
                        iter_d   = '0;
                        half_d   = bus.half_in;
                        square_d = bus.square_in;
                        busy_d   = 1'b1;
                        state_d  = ST_ROTATE;
                    end
                end
                ST_ROTATE: begin
                    // full-width wrap-around add/sub, no saturation
                    if (dir_pos) begin
                        x_d = x_q - y_shift;
                        y_d = y_q + x_shift;
                        z_d = z_q - atan_val;
                    end else begin
                        x_d = x_q + y_shift;
                        y_d = y_q - x_shift;
                        z_d = z_q + atan_val;
                    end
                    iter_d = iter_q + 1'b1;
                    if (iter_q == ITER_LAST) begin
                        state_d = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    cos_d   = x_q;
`ifdef CORDIC_SIN_OUT_EN
                    sin_d   = y_q;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // state and datapath registers; reset aborts any operation with no done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            cos_q    <= '0;
`ifdef CORDIC_SIN_OUT_EN
            sin_q    <= '0;
`endif
            iter_q   <= '0;
            half_q   <= '0;
            square_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            cos_q    <= cos_d;
`ifdef CORDIC_SIN_OUT_EN
            sin_q    <= sin_d;
`endif
            iter_q   <= iter_d;
            half_q   <= half_d;
            square_q <= square_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cos_out    = cos_q;
`ifdef CORDIC_SIN_OUT_EN
    assign bus.sin_out    = sin_q;
`endif
    assign bus.half_out   = half_q;
    assign bus.square_out = square_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_stage_two_cordic.sv
// Self-checking bench for stage_two_cordic: expected results come from real
// cos/sin of the requested angle and are queued at start, popped at done.
module tb_stage_two_cordic;
    import stage_two_cordic_pkg::*;

    localparam int TOL = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b1;

    always #5 clk = ~clk;

    stage_two_cordic_if bus ();

    stage_two_cordic dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus.slave)
    );

    typedef struct {
        int          cos_e;
        int          sin_e;
        logic [31:0] half_e;
        logic [31:0] sq_e;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic int cos_ref(input int th);
        real r;
        r = real'(th) / 1048576.0;
        return $rtoi($floor($cos(r) * 1048576.0 + 0.5));
    endfunction

    function automatic int sin_ref(input int th);
        real r;
        r = real'(th) / 1048576.0;
        return $rtoi($floor($sin(r) * 1048576.0 + 0.5));
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // present a request for one enabled edge and queue its expected result
    task automatic start_op(input int th, input logic [31:0] h, input logic [31:0] s);
        exp_t e;
        e.cos_e = cos_ref(th);
        e.sin_e = sin_ref(th);
        e.half_e = h;
        e.sq_e = s;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.theta = 22'(th);
        bus.half_in = h;
        bus.square_in = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.theta = 22'($urandom);
        bus.half_in = $urandom;
        bus.square_in = $urandom;
    endtask

    // count edges until done is seen high, bounded by budget
    task automatic wait_done(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < budget && !ok) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.cos_out !== 22'd0) begin errors++; $display("FAIL reset_cos got=%0d exp=0", bus.cos_out); end
        checks++; if (bus.half_out !== 32'd0) begin errors++; $display("FAIL reset_half got=%h exp=0", bus.half_out); end
        checks++; if (bus.square_out !== 32'd0) begin errors++; $display("FAIL reset_square got=%h exp=0", bus.square_out); end
`ifdef CORDIC_SIN_OUT_EN
        checks++; if (bus.sin_out !== 22'd0) begin errors++; $display("FAIL reset_sin got=%0d exp=0", bus.sin_out); end
`endif
    endtask

    task automatic test_zero();
        int cyc;
        bit ok;
        exp_t e;
        start_op(0, 32'h3F800000, 32'h40000000);
        wait_done(40, cyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || cyc != 17) begin errors++; $display("FAIL zero_latency got=%0d exp=17", cyc); end
        checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL zero_cos got=%0d exp=%0d", bus.cos_out, e.cos_e); end
`ifdef CORDIC_SIN_OUT_EN
        checks++; if (absdiff(int'(bus.sin_out), e.sin_e) > TOL) begin errors++; $display("FAIL zero_sin got=%0d exp=%0d", bus.sin_out, e.sin_e); end
`endif
        checks++; if (bus.half_out !== e.half_e) begin errors++; $display("FAIL zero_half got=%h exp=%h", bus.half_out, e.half_e); end
        checks++; if (bus.square_out !== e.sq_e) begin errors++; $display("FAIL zero_square got=%h exp=%h", bus.square_out, e.sq_e); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done got=%b exp=0", bus.busy); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_angles();
        int th_tab[4] = '{823550, -1048576, -823550, 1048576};
        int cyc;
        bit ok;
        exp_t e;
        logic [31:0] h;
        foreach (th_tab[i]) begin
            h = (th_tab[i] == -1048576) ? 32'h3F000000 : $urandom;
            start_op(th_tab[i], h, $urandom);
            wait_done(40, cyc, ok);
            e = sb.pop_front();
            checks++; if (!ok || cyc != 17) begin errors++; $display("FAIL angle%0d_latency got=%0d exp=17", i, cyc); end
            checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL angle%0d_cos got=%0d exp=%0d", i, bus.cos_out, e.cos_e); end
`ifdef CORDIC_SIN_OUT_EN
            checks++; if (absdiff(int'(bus.sin_out), e.sin_e) > TOL) begin errors++; $display("FAIL angle%0d_sin got=%0d exp=%0d", i, bus.sin_out, e.sin_e); end
`endif
            checks++; if (bus.half_out !== e.half_e || bus.square_out !== e.sq_e) begin
                errors++; $display("FAIL angle%0d_floats got=%h/%h exp=%h/%h", i, bus.half_out, bus.square_out, e.half_e, e.sq_e);
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int done_cnt;
        bit ok;
        exp_t e;
        start_op(823550, 32'h11111111, 32'h22222222);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.theta = -22'sd1048576;
        bus.half_in = 32'hDEADBEEF;
        bus.square_in = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(40, cyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || cyc + 5 != 17) begin errors++; $display("FAIL ignore_latency got=%0d exp=17", cyc + 5); end
        checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL ignore_cos got=%0d exp=%0d", bus.cos_out, e.cos_e); end
        checks++; if (bus.half_out !== e.half_e || bus.square_out !== e.sq_e) begin
            errors++; $display("FAIL ignore_floats got=%h/%h exp=%h/%h", bus.half_out, bus.square_out, e.half_e, e.sq_e);
        end
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL ignore_extra_activity got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_clk_en();
        int cyc;
        int bad;
        bit ok;
        exp_t e;
        start_op(-1048576, 32'h3F000000, 32'h3E800000);
        repeat (4) @(posedge clk);
        #1;
        clk_en = 1'b0;
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        clk_en = 1'b1;
        checks++; if (bad != 0) begin errors++; $display("FAIL clken_frozen_state got=%0d exp=0", bad); end
        wait_done(40, cyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || cyc + 11 != 24) begin errors++; $display("FAIL clken_latency got=%0d exp=24", cyc + 11); end
        checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL clken_cos got=%0d exp=%0d", bus.cos_out, e.cos_e); end
        checks++; if (bus.half_out !== e.half_e) begin errors++; $display("FAIL clken_half got=%h exp=%h", bus.half_out, e.half_e); end
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL clken_done_hold got=%b exp=1", bus.done); end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL clken_done_release got=%b exp=0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        exp_t e;
        start_op(823550, 32'hAAAA0001, 32'hBBBB0001);
        wait_done(40, cyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || cyc != 17) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=17", cyc); end
        checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL b2b_first_cos got=%0d exp=%0d", bus.cos_out, e.cos_e); end
        start_op(-1048576, 32'hAAAA0002, 32'hBBBB0002);
        wait_done(40, cyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || cyc != 17) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=17", cyc); end
        checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL b2b_second_cos got=%0d exp=%0d", bus.cos_out, e.cos_e); end
        checks++; if (bus.half_out !== e.half_e || bus.square_out !== e.sq_e) begin
            errors++; $display("FAIL b2b_second_floats got=%h/%h exp=%h/%h", bus.half_out, bus.square_out, e.half_e, e.sq_e);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        bit ok;
        exp_t e;
        start_op(1048576, 32'h12345678, 32'h9ABCDEF0);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
        #2;
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rstmid_async_flags got=%b/%b exp=0/0", bus.busy, bus.done);
        end
        checks++; if (bus.cos_out !== 22'd0 || bus.half_out !== 32'd0 || bus.square_out !== 32'd0) begin
            errors++; $display("FAIL rstmid_async_data got=%0d/%h/%h exp=0/0/0", bus.cos_out, bus.half_out, bus.square_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
        start_op(823550, 32'h0BADF00D, 32'h600DCAFE);
        wait_done(40, cyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || cyc != 17) begin errors++; $display("FAIL rstmid_after_latency got=%0d exp=17", cyc); end
        checks++; if (absdiff(int'(bus.cos_out), e.cos_e) > TOL) begin errors++; $display("FAIL rstmid_after_cos got=%0d exp=%0d", bus.cos_out, e.cos_e); end
        checks++; if (bus.half_out !== e.half_e || bus.square_out !== e.sq_e) begin
            errors++; $display("FAIL rstmid_after_floats got=%h/%h exp=%h/%h", bus.half_out, bus.square_out, e.half_e, e.sq_e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.theta = '0;
        bus.half_in = '0;
        bus.square_in = '0;
        rst = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_zero();
        test_angles();
        test_busy_ignore();
        test_clk_en();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
